// File: rtl/cnu_min_tracker.sv
// Serial min-sum row tracker for the check node unit: converts each incoming message to
// sign-magnitude and keeps min1/min2/index/signs, publishing the summary once per row.
module cnu_min_tracker #(
    parameter int unsigned W   = 6,
    parameter int unsigned DEG = 6,
    parameter int unsigned IW  = $clog2(DEG)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN_VALID,
    input  logic [W-1:0]   IN_DATA,
    output logic           OUT_VALID,
    output logic [W-2:0]   MIN1,
    output logic [W-2:0]   MIN2,
    output logic [IW-1:0]  MIN1_IDX,
    output logic [DEG-1:0] SIGNS,
    output logic           SIGN_XOR
);

    localparam logic [IW-1:0] LastIdx = IW'(DEG - 1);

    logic [W-1:0]   neg;
    logic [W:0]     carry;
    logic [W-2:0]   mag;
    logic           sign;
    logic           last;

    logic [IW-1:0]  cnt_q;
    logic [W-2:0]   m1_q, m1_d;
    logic [W-2:0]   m2_q, m2_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [DEG-1:0] sgn_q, sgn_d;
    logic           sx_q, sx_d;

    // Two's complement negation as an inverted operand through a ripple of full adders (+1).
    always_comb begin
        carry[0] = 1'b1;
        neg      = '0;
        for (int i = 0; i < int'(W); i++) begin
            neg[i]       = ~IN_DATA[i] ^ carry[i];
            carry[i + 1] = ~IN_DATA[i] & carry[i];
        end
    end

    // Only the most negative input still has its MSB set after negation; saturate it.
    assign sign = IN_DATA[W-1];
    assign mag  = !sign ? IN_DATA[W-2:0] : (neg[W-1] ? '1 : neg[W-2:0]);
    assign last = (cnt_q == LastIdx);

    always_comb begin
        m1_d  = m1_q;
        m2_d  = m2_q;
        idx_d = idx_q;
        sgn_d = sgn_q;
        sx_d  = sx_q;
        if (mag < m1_q) begin
            m2_d  = m1_q;
            m1_d  = mag;
            idx_d = cnt_q;
        end else if (mag < m2_q) begin
            m2_d = mag;
        end
        sgn_d[cnt_q] = sign;
        sx_d         = sx_q ^ sign;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            m1_q      <= '1;
            m2_q      <= '1;
            idx_q     <= '0;
            sgn_q     <= '0;
            sx_q      <= 1'b0;
            OUT_VALID <= 1'b0;
            MIN1      <= '0;
            MIN2      <= '0;
            MIN1_IDX  <= '0;
            SIGNS     <= '0;
            SIGN_XOR  <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID && last;
            if (IN_VALID) begin
                if (last) begin
                    MIN1     <= m1_d;
                    MIN2     <= m2_d;
                    MIN1_IDX <= idx_d;
                    SIGNS    <= sgn_d;
                    SIGN_XOR <= sx_d;
                    cnt_q    <= '0;
                    m1_q     <= '1;
                    m2_q     <= '1;
                    idx_q    <= '0;
                    sgn_q    <= '0;
                    sx_q     <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    m1_q  <= m1_d;
                    m2_q  <= m2_d;
                    idx_q <= idx_d;
                    sgn_q <= sgn_d;
                    sx_q  <= sx_d;
                end
            end
        end
    end

endmodule

// File: doc/cnu_min_tracker.md
# cnu_min_tracker

Sequential min-sum core of the check node unit (CNU). Accepts the DEG variable-to-check messages of one parity-check row serially, one per valid cycle. Converts each message from two's complement to sign-magnitude, using the same full-adder negation path as the rest of the CNU. Tracks the smallest magnitude, second-smallest magnitude, index of the smallest, per-edge signs and their XOR, then presents the row summary to the downstream check-to-variable message generator.

## Interface
- W, default 6: message width, two's complement; magnitudes are W-1 bits.
- DEG, default 6: check node degree (messages per row), 2..16.
- IW, default $clog2(DEG): index width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  IN_DATA valid this cycle; always accepted (no backpressure).
- IN_DATA  in  W  variable-to-check message, two's complement.
- OUT_VALID  out  1  one-cycle pulse: row summary updated.
- MIN1  out  W-1  smallest magnitude of the row.
- MIN2  out  W-1  second-smallest magnitude (equals MIN1 on a tie).
- MIN1_IDX  out  IW  edge index (0..DEG-1) of MIN1.
- SIGNS  out  DEG  bit i = sign of edge i (1 = negative).
- SIGN_XOR  out  1  XOR of all DEG signs.

## Operation
- Magnitude: mag = |IN_DATA|. The most negative input (-2^(W-1)) saturates to 2^(W-1)-1. Truncating it to zero is a defect.
- Internal state:
  - edge counter cnt, 0..DEG-1
  - working registers m1, m2, idx, sgn[DEG-1:0], sx
- Row start state: m1 = m2 = all ones, idx = 0, sgn = 0, sx = 0, cnt = 0.
- On each accepted message (IN_VALID=1), with edge number cnt:
  - if mag < m1: m2 <= m1, m1 <= mag, idx <= cnt
  - else if mag < m2: m2 <= mag
  - sgn[cnt] <= IN_DATA[W-1]; sx <= sx ^ IN_DATA[W-1]
  - cnt <= cnt+1
- Ties: a later equal magnitude never displaces MIN1_IDX (earliest index wins). It may lower m2 to the same value.
- Last message (cnt = DEG-1):
  - final values, including this message's update, are loaded into the outputs
  - OUT_VALID asserts
  - working state returns to the row start state in the same edge
- Cycles with IN_VALID=0 change nothing; gaps within a row are legal.
- Outputs hold their last row summary until the next OUT_VALID.

## Timing
- Reset (RST_N low, asynchronous):
  - OUT_VALID=0, MIN1=0, MIN2=0, MIN1_IDX=0, SIGNS=0, SIGN_XOR=0
  - working state goes to the row start state
- Reset mid-row discards the partial row and emits no OUT_VALID. The first message after release is edge 0.
- Latency: outputs and OUT_VALID are registered and visible the cycle after the clock edge that accepts edge DEG-1.
- OUT_VALID is high for exactly one cycle per completed row.
- Back-to-back rows: edge 0 of the next row may be accepted in the same cycle OUT_VALID is high. Minimum row period is DEG cycles; no bubble is required.
- Counter wraps DEG-1 -> 0 only on acceptance of the last edge. cnt never reaches DEG.

## Test plan
- Reset values: hold RST_N low, drive random IN_DATA with IN_VALID=1 -> all outputs 0, no OUT_VALID.
- Basic row, W=6, DEG=6, inputs 5, -3, 7, -12, 3, 20 consecutive -> one cycle after the sixth accept:
  - OUT_VALID=1 for one cycle
  - MIN1=3, MIN2=3, MIN1_IDX=1, SIGNS=6'b001010, SIGN_XOR=0
- Saturation and ordering, inputs -32, 31, -1, 0, 31, -31:
  - MIN1=0, MIN2=1, MIN1_IDX=3, SIGNS=6'b100101, SIGN_XOR=1
  - MIN1_IDX=0 indicates the saturation bug
- Gapped input: the basic row with IN_VALID low for 1-3 random cycles between edges -> identical outputs; OUT_VALID one cycle after the last accept.
- Back-to-back: basic row immediately followed by the saturation row, no idle cycle -> two OUT_VALID pulses exactly 6 cycles apart, with the values above in order.
- Reset mid-row:
  - accept 3 edges of the saturation row, pulse RST_N low, then send the full basic row
  - no OUT_VALID before the basic row completes
  - basic row results appear exactly as specified
